accum_sched: RTL

ACCUM_SCHED -- requirements
Module: accum_sched

---
 rtl/accum_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/accum_sched.sv
// Two-requester job scheduler driving an external accumulator: grants a job, streams its beats, returns the sum.
// Build option: define ACCUM_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module accum_sched #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 14,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [IN_W-1:0]  din0,
    input  logic [IN_W-1:0]  din1,
    input  logic             dvalid0,
    input  logic             dvalid1,
    output logic             dready0,
    output logic             dready1,
    output logic [1:0]       gnt,
    output logic [OUT_W-1:0] res,
    output logic             res_id,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IN_W-1:0]  acc_in,
    output logic             acc_en,
    output logic             acc_clr,
    input  logic [OUT_W-1:0] acc_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [1:0]         gnt_r, gnt_s;
    logic [LEN_W-1:0]   cnt_r, cnt_s;
    logic [OUT_W-1:0]   res_r, res_s;
    logic               res_id_r, res_id_s;
    logic               res_valid_r, res_valid_s;
    logic               win_s;
    logic               run_s;
    logic               sel_s;
    logic               vsel_s;
    logic [IN_W-1:0]    dsel_s;
    logic               accept_s;

`ifdef ACCUM_SCHED_RR_EN
    logic               ptr_r, ptr_s;

    // Round-robin: on a tie the pointer names the favoured requester.
    assign win_s = (req0 && req1) ? ptr_r : req1;
`else
    assign win_s = !req0;
`endif

    // Beat path: only the granted requester is visible while running.
    assign run_s    = (state_r == RUN);
    assign sel_s    = gnt_r[1];
    assign vsel_s   = sel_s ? dvalid1 : dvalid0;
    assign dsel_s   = sel_s ? din1 : din0;
    assign accept_s = run_s && vsel_s;

    assign dready0   = run_s && gnt_r[0];
    assign dready1   = run_s && gnt_r[1];
    assign acc_en    = accept_s;
    assign acc_in    = accept_s ? dsel_s : {IN_W{1'b0}};
    assign acc_clr   = reset || (state_r == CLEAR);
    assign gnt       = gnt_r;
    assign res       = res_r;
    assign res_id    = res_id_r;
    assign res_valid = res_valid_r;

    // Next-state and next-register values for the job sequencer.
    always_comb begin
        state_s     = state_r;
        gnt_s       = gnt_r;
        cnt_s       = cnt_r;
        res_s       = res_r;
        res_id_s    = res_id_r;
        res_valid_s = res_valid_r;
`ifdef ACCUM_SCHED_RR_EN
        ptr_s       = ptr_r;
`endif
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_s   = win_s ? 2'b10 : 2'b01;
                    cnt_s   = win_s ? len1 : len0;
                    state_s = CLEAR;
`ifdef ACCUM_SCHED_RR_EN
                    ptr_s   = !win_s;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                if (cnt_r != {LEN_W{1'b0}}) begin
                    state_s = RUN;
                end else begin
                    state_s = DRAIN;
                end
            end
            RUN: begin
                if (accept_s) begin
                    cnt_s = cnt_r - LEN_W'(1);
                    if (cnt_r == LEN_W'(1)) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                // Last beat landed in the accumulator on the previous edge.
                res_s       = acc_out;
                res_id_s    = sel_s;
                res_valid_s = 1'b1;
                state_s     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_s = 1'b0;
                    gnt_s       = 2'b00;
                    state_s     = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s     = IDLE;
                gnt_s       = 2'b00;
                res_valid_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant, beat counter and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_r       <= 2'b00;
            cnt_r       <= {LEN_W{1'b0}};
            res_r       <= {OUT_W{1'b0}};
            res_id_r    <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            gnt_r       <= gnt_s;
            cnt_r       <= cnt_s;
            res_r       <= res_s;
            res_id_r    <= res_id_s;
            res_valid_r <= res_valid_s;
        end
    end

`ifdef ACCUM_SCHED_RR_EN
    // Round-robin pointer; starts favouring requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= 1'b0;
        end else begin
            ptr_r <= ptr_s;
        end
    end
`endif

endmodule
